// File: rtl/core_inst_seq.sv
// Instruction sequencer for one 3x3 conv tile: weight/activation loads, execute,
// OFIFO drain to psum SRAM, then per-pixel SFU accumulation over all kernel taps.
module core_inst_seq #(
    parameter int COL      = 8,
    parameter int ROW      = 8,
    parameter int LEN_NIJ  = 36,
    parameter int IN_W     = 6,
    parameter int KER_W    = 3,
    parameter int LEN_ONIJ = 16,
    parameter int W_BASE   = 1024,
    parameter int GAP      = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic        psum_clr,
    output logic        out_valid,
    output logic        busy,
    output logic        done
);

    localparam int LEN_KIJ = KER_W * KER_W;
    localparam int OUT_W   = IN_W - KER_W + 1;

    localparam logic [10:0] K_COL      = 11'(COL);
    localparam logic [10:0] K_LOAD_END = 11'(2 * COL - 1);
    localparam logic [10:0] K_GAP_END  = 11'(GAP - 1);
    localparam logic [10:0] K_NIJ      = 11'(LEN_NIJ);
    localparam logic [10:0] K_EXEC_END = 11'(LEN_NIJ + ROW + COL - 1);
    localparam logic [10:0] K_KIJ      = 11'(LEN_KIJ);
    localparam logic [10:0] K_KIJ_END  = 11'(LEN_KIJ - 1);
    localparam logic [10:0] K_ONIJ_END = 11'(LEN_ONIJ - 1);
    localparam logic [10:0] K_OUT_END  = 11'(OUT_W - 1);
    localparam logic [10:0] K_KER_END  = 11'(KER_W - 1);
    localparam logic [10:0] K_W_BASE   = 11'(W_BASE);
    localparam logic [10:0] K_IN_W     = 11'(IN_W);

    localparam logic [33:0] INST_IDLE = 34'h1_800C_0000;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_WL0   = 4'd1;
    localparam logic [3:0] S_LOAD  = 4'd2;
    localparam logic [3:0] S_GAP   = 4'd3;
    localparam logic [3:0] S_XL0   = 4'd4;
    localparam logic [3:0] S_EXEC  = 4'd5;
    localparam logic [3:0] S_OFIFO = 4'd6;
    localparam logic [3:0] S_CLR   = 4'd7;
    localparam logic [3:0] S_RD    = 4'd8;
    localparam logic [3:0] S_END   = 4'd9;
    localparam logic [3:0] S_DONE  = 4'd10;

    logic [3:0]  state, state_n;
    logic [10:0] cnt, cnt_n;
    logic [10:0] kij, kij_n;
    logic [10:0] o, o_n, ox, ox_n, oy, oy_n;
    logic [10:0] jx, jx_n, jy, jy_n;

    logic [33:0] inst_d;
    logic        clr_d, ov_d, busy_d, done_d;

    // In OFIFO, cnt counts beats already issued; inst[6] marks a beat issued this cycle.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 11'd1;
        kij_n   = kij;
        o_n     = o;
        ox_n    = ox;
        oy_n    = oy;
        jx_n    = jx;
        jy_n    = jy;
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (start) begin
                    state_n = S_WL0;
                    kij_n   = '0;
                end
            end
            S_WL0:  if (cnt == K_COL)      begin state_n = S_LOAD;  cnt_n = '0; end
            S_LOAD: if (cnt == K_LOAD_END) begin state_n = S_GAP;   cnt_n = '0; end
            S_GAP:  if (cnt == K_GAP_END)  begin state_n = S_XL0;   cnt_n = '0; end
            S_XL0:  if (cnt == K_NIJ)      begin state_n = S_EXEC;  cnt_n = '0; end
            S_EXEC: if (cnt == K_EXEC_END) begin state_n = S_OFIFO; cnt_n = '0; end
            S_OFIFO: begin
                cnt_n = cnt + {10'd0, inst[6]};
                if (cnt_n == K_NIJ) begin
                    cnt_n = '0;
                    if (kij == K_KIJ_END) begin
                        state_n = S_CLR;
                        o_n     = '0;
                        ox_n    = '0;
                        oy_n    = '0;
                    end else begin
                        state_n = S_WL0;
                        kij_n   = kij + 11'd1;
                    end
                end
            end
            S_CLR: begin
                state_n = S_RD;
                cnt_n   = '0;
                jx_n    = '0;
                jy_n    = '0;
            end
            S_RD: begin
                if (cnt == K_KIJ) begin
                    state_n = S_END;
                    cnt_n   = '0;
                end else if (jx == K_KER_END) begin
                    jx_n = '0;
                    jy_n = jy + 11'd1;
                end else begin
                    jx_n = jx + 11'd1;
                end
            end
            S_END: begin
                cnt_n = '0;
                if (o == K_ONIJ_END) begin
                    state_n = S_DONE;
                end else begin
                    state_n = S_CLR;
                    o_n     = o + 11'd1;
                    if (ox == K_OUT_END) begin
                        ox_n = '0;
                        oy_n = oy + 11'd1;
                    end else begin
                        ox_n = ox + 11'd1;
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs decode the upcoming cycle so they can be registered without adding latency.
    always_comb begin
        inst_d = INST_IDLE;
        clr_d  = 1'b0;
        ov_d   = 1'b0;
        done_d = 1'b0;
        busy_d = (state_n != S_IDLE);
        case (state_n)
            S_WL0: begin
                if (cnt_n < K_COL) begin
                    inst_d[19]   = 1'b0;
                    inst_d[17:7] = K_W_BASE + kij_n * K_COL + cnt_n;
                end
                if (cnt_n != '0) inst_d[5] = 1'b1;
            end
            S_LOAD: begin
                inst_d[4] = 1'b1;
                inst_d[0] = 1'b1;
            end
            S_GAP: inst_d[0] = 1'b1;
            S_XL0: begin
                if (cnt_n < K_NIJ) begin
                    inst_d[19]   = 1'b0;
                    inst_d[17:7] = cnt_n;
                end
                if (cnt_n != '0) inst_d[2] = 1'b1;
            end
            S_EXEC: begin
                inst_d[3] = 1'b1;
                inst_d[1] = 1'b1;
            end
            S_OFIFO: begin
                if (ofifo_valid) begin
                    inst_d[6]     = 1'b1;
                    inst_d[32]    = 1'b0;
                    inst_d[31]    = 1'b0;
                    inst_d[30:20] = kij_n * K_NIJ + cnt_n;
                end
            end
            S_CLR: clr_d = 1'b1;
            S_RD: begin
                if (cnt_n < K_KIJ) begin
                    inst_d[32]    = 1'b0;
                    inst_d[30:20] = cnt_n * K_NIJ + (oy_n + jy_n) * K_IN_W + ox_n + jx_n;
                end
                if (cnt_n != '0) inst_d[33] = 1'b1;
            end
            S_END:  ov_d   = 1'b1;
            S_DONE: done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            kij       <= '0;
            o         <= '0;
            ox        <= '0;
            oy        <= '0;
            jx        <= '0;
            jy        <= '0;
            inst      <= INST_IDLE;
            psum_clr  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            kij       <= kij_n;
            o         <= o_n;
            ox        <= ox_n;
            oy        <= oy_n;
            jx        <= jx_n;
            jy        <= jy_n;
            inst      <= inst_d;
            psum_clr  <= clr_d;
            out_valid <= ov_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule
